tile_pattern_generator: RTL and testbench

//  Parametrised, multi-mode successor to the fixed 800x600 DVI test-pattern source.
//  - Streams one 24-bit RGB pixel per accepted handshake, in raster order.
//  - Generates configurable tile, bar, solid and gradient patterns, with periodic palette inversion.
//  - Sits upstream of the DVI/video sink; used for bring-up and for feature-detection pipeline stimulus.

---
 rtl/tile_pattern_generator.sv | 219 +++++++++++++++++++++
 tb/tb_tile_pattern_generator.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tile_pattern_generator.sv
// tile_pattern_generator
//
// Raster-order RGB test-pattern source with a valid/ready handshake. One
// 24-bit pixel {R,G,B} is presented per accepted handshake. Four pattern
// modes are available: a two-by-two tile checkerboard, four-colour vertical
// bars, a solid colour, and an x/y/frame gradient. The palette can be
// inverted periodically every INVERT_PERIOD frames.
//
// Ports
//   clock        in   1   single clock, all logic on the rising edge
//   reset        in   1   synchronous, active-high
//   Mode         in   2   pattern select, sampled only at frame start
//   VideoReady   in   1   sink accepts the current pixel this cycle
//   VideoValid   out  1   Video holds a valid pixel
//   Video        out  24  pixel {R[7:0],G[7:0],B[7:0]}
//   StartOfFrame out  1   high while pixel (0,0) is presented      (optional)
//   EndOfLine    out  1   high while the last pixel of a line is shown (optional)
//
// Build option
//   PATGEN_SYNC_FLAGS_EN : when defined, adds the StartOfFrame and EndOfLine
//                          outputs. When undefined they do not exist.

module tile_pattern_generator #(
    parameter int          WIDTH         = 800,
    parameter int          HEIGHT        = 600,
    parameter int          TILE_W        = 64,
    parameter int          TILE_H        = 32,
    parameter int          INVERT_PERIOD = 72,
    parameter logic [23:0] COLOR0        = 24'h00CC00,
    parameter logic [23:0] COLOR1        = 24'h00CCCC,
    parameter logic [23:0] COLOR2        = 24'hFF9A26,
    parameter logic [23:0] COLOR3        = 24'h9D26FF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  Mode,
    input  logic        VideoReady,
    output logic        VideoValid,
    output logic [23:0] Video
`ifdef PATGEN_SYNC_FLAGS_EN
    ,
    output logic        StartOfFrame,
    output logic        EndOfLine
`endif
);

    // Coordinates are at least 8 bits wide so the gradient can always take
    // the low byte, even for tiny frame sizes.
    localparam int XW  = ($clog2(WIDTH)  > 8) ? $clog2(WIDTH)  : 8;
    localparam int YW  = ($clog2(HEIGHT) > 8) ? $clog2(HEIGHT) : 8;
    localparam int TXW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int TYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int IW  = (INVERT_PERIOD > 1) ? $clog2(INVERT_PERIOD + 1) : 1;

    localparam logic [XW-1:0]  X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0]  Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [TXW-1:0] TX_LAST = TXW'(TILE_W - 1);
    localparam logic [TYW-1:0] TY_LAST = TYW'(TILE_H - 1);
    localparam logic [IW-1:0]  INV_LAST = IW'(INVERT_PERIOD - 1);

    typedef enum logic [1:0] {
        MODE_CHECKER  = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_SOLID    = 2'd2,
        MODE_GRADIENT = 2'd3
    } modeT;

    logic [XW-1:0]  x,        nextX;
    logic [YW-1:0]  y,        nextY;
    logic [TXW-1:0] tx,       nextTx;
    logic [TYW-1:0] ty,       nextTy;
    logic           col,      nextCol;
    logic           row,      nextRow;
    logic [1:0]     bar,      nextBar;
    logic [15:0]    frame,    nextFrame;
    logic [IW-1:0]  invCount, nextInvCount;
    logic           inverted, nextInverted;
    modeT           modeLatched, nextMode;
    logic [23:0]    nextVideo;
    logic           accept;
    logic           lineWrap;
    logic           frameWrap;

    // Palette lookup with optional inversion of every entry.
    function automatic logic [23:0] paletteColor(input logic [1:0] idx, input logic inv);
        logic [23:0] c;
        c = COLOR0;
        case (idx)
            2'd0:    c = COLOR0;
            2'd1:    c = COLOR1;
            2'd2:    c = COLOR2;
            default: c = COLOR3;
        endcase
        return inv ? ~c : c;
    endfunction

    // Next raster/tile/frame state. Counters only advance on an accepted
    // pixel; while the output is stalled (or not yet valid) everything holds,
    // so recomputing the pixel from the held state leaves Video unchanged.
    // The mode is re-sampled while the output is not yet valid (reset
    // release) and on the frame wrap, so it is constant across a frame.
    always_comb begin
        accept       = VideoValid && VideoReady;
        lineWrap     = (x == X_LAST);
        frameWrap    = accept && lineWrap && (y == Y_LAST);
        nextX        = x;
        nextY        = y;
        nextTx       = tx;
        nextTy       = ty;
        nextCol      = col;
        nextRow      = row;
        nextBar      = bar;
        nextFrame    = frame;
        nextInvCount = invCount;
        nextInverted = inverted;
        nextMode     = (!VideoValid || frameWrap) ? modeT'(Mode) : modeLatched;

        if (accept) begin
            if (lineWrap) begin
                nextX   = '0;
                nextTx  = '0;
                nextCol = 1'b0;
                nextBar = 2'd0;
                if (y == Y_LAST) begin
                    nextY     = '0;
                    nextTy    = '0;
                    nextRow   = 1'b0;
                    nextFrame = frame + 16'd1;
                    if (INVERT_PERIOD != 0) begin
                        if (invCount == INV_LAST) begin
                            nextInvCount = '0;
                            nextInverted = ~inverted;
                        end else begin
                            nextInvCount = invCount + 1'b1;
                        end
                    end
                end else begin
                    nextY = y + 1'b1;
                    if (ty == TY_LAST) begin
                        nextTy  = '0;
                        nextRow = ~row;
                    end else begin
                        nextTy = ty + 1'b1;
                    end
                end
            end else begin
                nextX = x + 1'b1;
                if (tx == TX_LAST) begin
                    nextTx  = '0;
                    nextCol = ~col;
                    nextBar = bar + 2'd1;
                end else begin
                    nextTx = tx + 1'b1;
                end
            end
        end
    end

    // Pixel colour for the next counter state, so the registered Video moves
    // together with x/y.
    always_comb begin
        nextVideo = '0;
        unique case (nextMode)
            MODE_CHECKER:  nextVideo = paletteColor({nextRow, nextCol}, nextInverted);
            MODE_BARS:     nextVideo = paletteColor(nextBar, nextInverted);
            MODE_SOLID:    nextVideo = paletteColor(2'd0, nextInverted);
            MODE_GRADIENT: nextVideo = {nextX[7:0], nextY[7:0], nextFrame[7:0]};
        endcase
    end

    // State and output registers. Reset parks everything at the origin with
    // the output invalid; the first non-reset edge raises VideoValid and
    // presents pixel (0,0) for the freshly sampled mode.
    always_ff @(posedge clock) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            tx          <= '0;
            ty          <= '0;
            col         <= 1'b0;
            row         <= 1'b0;
            bar         <= 2'd0;
            frame       <= '0;
            invCount    <= '0;
            inverted    <= 1'b0;
            modeLatched <= modeT'(Mode);
            VideoValid  <= 1'b0;
            Video       <= '0;
        end else begin
            x           <= nextX;
            y           <= nextY;
            tx          <= nextTx;
            ty          <= nextTy;
            col         <= nextCol;
            row         <= nextRow;
            bar         <= nextBar;
            frame       <= nextFrame;
            invCount    <= nextInvCount;
            inverted    <= nextInverted;
            modeLatched <= nextMode;
            VideoValid  <= 1'b1;
            Video       <= nextVideo;
        end
    end

`ifdef PATGEN_SYNC_FLAGS_EN
    // Frame/line markers registered alongside Video from the same next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            StartOfFrame <= 1'b0;
            EndOfLine    <= 1'b0;
        end else begin
            StartOfFrame <= (nextX == '0) && (nextY == '0);
            EndOfLine    <= (nextX == X_LAST);
        end
    end
`endif

endmodule

// File: tb/tb_tile_pattern_generator.sv
// Testbench for tile_pattern_generator using a small frame geometry so that
// many frames and several palette inversions fit in a short run. Expected
// pixels come from a reference model that evaluates the pattern rules
// directly from (x, y, frame, mode) with division and modulo.

module tb_tile_pattern_generator;

    localparam int W  = 13;
    localparam int H  = 7;
    localparam int TW = 4;
    localparam int TH = 3;
    localparam int IP = 3;

    localparam logic [23:0] C0 = 24'h00CC00;
    localparam logic [23:0] C1 = 24'h00CCCC;
    localparam logic [23:0] C2 = 24'hFF9A26;
    localparam logic [23:0] C3 = 24'h9D26FF;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  Mode = 2'd0;
    logic        VideoReady = 1'b0;
    logic        VideoValid;
    logic [23:0] Video;
`ifdef PATGEN_SYNC_FLAGS_EN
    logic        StartOfFrame;
    logic        EndOfLine;
`endif

    int errors = 0;
    int checks = 0;

    int         mx;
    int         my;
    int         mframe;
    logic [1:0] mmode;

    // Free-running clock.
    always #5 clock = ~clock;

    tile_pattern_generator #(
        .WIDTH(W), .HEIGHT(H), .TILE_W(TW), .TILE_H(TH), .INVERT_PERIOD(IP),
        .COLOR0(C0), .COLOR1(C1), .COLOR2(C2), .COLOR3(C3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .Mode(Mode),
        .VideoReady(VideoReady),
        .VideoValid(VideoValid),
        .Video(Video)
`ifdef PATGEN_SYNC_FLAGS_EN
        ,
        .StartOfFrame(StartOfFrame),
        .EndOfLine(EndOfLine)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at x=%0d y=%0d frame=%0d t=%0t",
                     tag, got, exp, mx, my, mframe, $time);
        end
    endtask

    // Reference pixel straight from the pattern rules.
    function automatic logic [23:0] refPixel(input int px, input int py, input int fr, input logic [1:0] md);
        logic [23:0] pal[4];
        logic        inv;
        int          idx;
        pal[0] = C0;
        pal[1] = C1;
        pal[2] = C2;
        pal[3] = C3;
        inv = (IP != 0) && (((fr / IP) % 2) == 1);
        if (md == 2'd3) return {8'(px), 8'(py), 8'(fr)};
        case (md)
            2'd0:    idx = ((py / TH) % 2) * 2 + ((px / TW) % 2);
            2'd1:    idx = (px / TW) % 4;
            default: idx = 0;
        endcase
        return inv ? ~pal[idx] : pal[idx];
    endfunction

    // One clock of streaming: check what is presented now, then drive ready
    // (and occasionally a new Mode) for the next edge and advance the model
    // if that edge accepts the pixel.
    task automatic applyStimulus(input int readyPct);
        @(negedge clock);
        checkOutput("valid", 24'(VideoValid), 24'd1);
        checkOutput("pixel", Video, refPixel(mx, my, mframe, mmode));
`ifdef PATGEN_SYNC_FLAGS_EN
        checkOutput("sof", 24'(StartOfFrame), 24'((mx == 0) && (my == 0)));
        checkOutput("eol", 24'(EndOfLine), 24'(mx == W - 1));
`endif
        VideoReady = ($urandom_range(0, 99) < readyPct);
        if ($urandom_range(0, 39) == 0) Mode = 2'($urandom_range(0, 3));
        if (VideoReady) begin
            if (mx == W - 1) begin
                mx = 0;
                if (my == H - 1) begin
                    my = 0;
                    mframe++;
                    mmode = Mode;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
    endtask

    // Release reset at a falling edge with the given mode and restart the model.
    task automatic releaseReset(input logic [1:0] md);
        Mode       = md;
        VideoReady = 1'b0;
        reset      = 1'b0;
        mx         = 0;
        my         = 0;
        mframe     = 0;
        mmode      = md;
    endtask

    // Test sequence: reset state, continuous streaming, stalled streaming,
    // mid-frame reset, then continuous streaming again.
    initial begin
        mx = 0;
        my = 0;
        mframe = 0;
        mmode = 2'd0;
        repeat (3) @(negedge clock);
        checkOutput("resetValid", 24'(VideoValid), 24'd0);
`ifdef PATGEN_SYNC_FLAGS_EN
        checkOutput("resetSof", 24'(StartOfFrame), 24'd0);
`endif
        releaseReset(2'd0);
        @(negedge clock);
        checkOutput("firstPixel", Video, 24'h00CC00);
        mx = 0;
        VideoReady = 1'b1;
        if (VideoReady) mx = 1;

        for (int i = 0; i < 300; i++) applyStimulus(100);
        for (int i = 0; i < 3000; i++) applyStimulus(50);

        reset = 1'b1;
        @(negedge clock);
        checkOutput("midResetValid", 24'(VideoValid), 24'd0);
`ifdef PATGEN_SYNC_FLAGS_EN
        checkOutput("midResetSof", 24'(StartOfFrame), 24'd0);
`endif
        releaseReset(2'd0);
        @(negedge clock);
        checkOutput("restartPixel", Video, 24'h00CC00);
        checkOutput("restartValid", 24'(VideoValid), 24'd1);
`ifdef PATGEN_SYNC_FLAGS_EN
        checkOutput("restartSof", 24'(StartOfFrame), 24'd1);
`endif
        VideoReady = 1'b1;
        mx = 1;

        for (int i = 0; i < 2500; i++) applyStimulus(100);
        for (int i = 0; i < 1500; i++) applyStimulus(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
